// File: rtl/peb_psum_buf.sv
// Per-PEB partial-sum line buffer: overwrite/accumulate psum lines from the PEB, drain them out with valid/ready.
// Optional macro PSUM_SAT_EN: saturating accumulate with a sticky sat_flag (wrapping accumulate when undefined).
module peb_psum_buf #(
    parameter int LANES      = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = LANES * PSUM_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_val,
    output logic          cmd_rdy,
    input  logic [1:0]    cmd_op,
    input  logic [AW:0]   cmd_lines,
    input  logic          psum_val,
    output logic          psum_rdy,
    input  logic [LW-1:0] psum_data,
    output logic          rd_val,
    input  logic          rd_rdy,
    output logic [LW-1:0] rd_data,
    output logic          done,
    output logic          sat_flag
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW:0]     n_q, n_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            rd_val_q, rd_val_d;
    logic [LW-1:0]   rd_data_q, rd_data_d;
    logic            done_q, done_d;

    logic [LW-1:0]   mem [DEPTH];
    logic [LW-1:0]   mem_rd_line;
    logic [LW-1:0]   acc_line;
    logic [LW-1:0]   wr_line;
    logic            mem_we;
    logic            acc_we;
    logic [AW:0]     n_clamp;
    logic            last;

    assign n_clamp     = (cmd_lines > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cmd_lines;
    assign last        = ({1'b0, ptr_q} == (n_q - 1'b1));
    assign mem_rd_line = mem[ptr_q];
    assign wr_line     = acc_we ? acc_line : psum_data;

`ifdef PSUM_SAT_EN
    logic [LANES-1:0] lane_ovf;
`endif

    // Lane-wise signed add for accumulate; read-modify-write happens in one cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [PSUM_WIDTH-1:0] a_lane;
        logic signed [PSUM_WIDTH-1:0] b_lane;
        assign a_lane = mem_rd_line[gi*PSUM_WIDTH +: PSUM_WIDTH];
        assign b_lane = psum_data[gi*PSUM_WIDTH +: PSUM_WIDTH];
`ifdef PSUM_SAT_EN
        logic signed [PSUM_WIDTH:0] sum_ext;
        assign sum_ext      = {a_lane[PSUM_WIDTH-1], a_lane} + {b_lane[PSUM_WIDTH-1], b_lane};
        assign lane_ovf[gi] = sum_ext[PSUM_WIDTH] ^ sum_ext[PSUM_WIDTH-1];
        assign acc_line[gi*PSUM_WIDTH +: PSUM_WIDTH] =
            !lane_ovf[gi]        ? sum_ext[PSUM_WIDTH-1:0] :
            sum_ext[PSUM_WIDTH]  ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} :
                                   {1'b0, {(PSUM_WIDTH-1){1'b1}}};
`else
        assign acc_line[gi*PSUM_WIDTH +: PSUM_WIDTH] = a_lane + b_lane;
`endif
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        n_d       = n_q;
        ptr_d     = ptr_q;
        rd_val_d  = rd_val_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        acc_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    op_d  = cmd_op;
                    n_d   = n_clamp;
                    ptr_d = '0;
                    if (n_clamp == '0 || cmd_op == 2'b11) begin
                        done_d = 1'b1;
                    end else if (cmd_op == 2'b10) begin
                        state_d   = ST_DRAIN;
                        rd_val_d  = 1'b1;
                        rd_data_d = mem[0];
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (psum_val) begin
                    mem_we = 1'b1;
                    acc_we = (op_q == 2'b01);
                    ptr_d  = ptr_q + 1'b1;
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // rd_data is held until the consumer takes the current line.
                if (rd_rdy) begin
                    if (last) begin
                        state_d  = ST_IDLE;
                        rd_val_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        ptr_d     = ptr_q + 1'b1;
                        rd_data_d = mem[ptr_q + 1'b1];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            n_q       <= '0;
            ptr_q     <= '0;
            rd_val_q  <= 1'b0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            n_q       <= n_d;
            ptr_q     <= ptr_d;
            rd_val_q  <= rd_val_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

    // Line storage is intentionally not reset; an aborted write keeps its partial contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= wr_line;
        end
    end

`ifdef PSUM_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (cmd_val && state_q == ST_IDLE) begin
            sat_d = 1'b0;
        end else if (acc_we && mem_we && (|lane_ovf)) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    assign cmd_rdy  = (state_q == ST_IDLE);
    assign psum_rdy = (state_q == ST_WRITE);
    assign rd_val   = rd_val_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;

endmodule
